his_builder_fsm: RTL and testbench
==================================

// Module: his_builder_fsm
// PURPOSE
//  Two-phase histogram builder for the SiFH dTOF chain. Accumulates one count per
//  accepted time-bin address into a register-array histogram: first a coarse
//  histogram (CH, hisNum=0), then a fine histogram (FH, hisNum=1).
//  Streams the updated count of the written bin to the downstream peak detector.
//  Flags the end of each acquisition phase.
// PARAMETERS
//  NP          8  width of addr (rough TOF code, bits [NP:1])
//  NB          6  bin-address width; histogram has 2**NB entries, bin 0 unused
//  PEAK_MAX    8  width of one bin counter / binCounts
//  ACQ_PER_HIS 4  wrEn events per histogram phase
// PORTS
//  clk               in   1         rising-edge clock
//  res               in   1         synchronous active-low reset
//  wrEn              in   1         one acquisition event this cycle
//  addr              in   [NP:1]    bin address of the event
//  binCounts         out  PEAK_MAX  updated count of last written bin (registered)
//  acq_count_finish  out  1         one-cycle pulse: current phase completed
//  hisNum            out  1         0 = CH phase, 1 = FH phase / done
// BEHAVIOUR
//  - Reset (res=0 at posedge): state=S_CH, all bins=0, event counter=0,
//    binCounts=0, acq_count_finish=0, hisNum=0. Reset wins over every other event.
//  - States: S_CH (hisNum=0) -> S_FH (hisNum=1) -> S_DONE (hisNum=1, absorbing until reset).
//  - Event = wrEn=1 in S_CH or S_FH. Every event increments the phase counter.
//  - An event is accepted if addr!=0 and addr[NP:NB+1]==0.
//  - A rejected event still counts toward ACQ_PER_HIS but changes no bin.
//  - Accepted event, bin b=addr[NB:1]:
//    - bin[b] <= bin[b]+1.
//    - binCounts <= bin[b]+1 (1-cycle latency).
//  - Otherwise binCounts holds its value.
//  - Multiple events to the same bin on consecutive cycles must accumulate correctly.
//    A read-modify-write hazard is not allowed.
//  - Event that makes counter == ACQ_PER_HIS: at that edge:
//    - the bin update and binCounts are still performed;
//    - acq_count_finish <= 1 for exactly one cycle;
//    - counter <= 0;
//    - all bins are cleared for the next phase;
//    - state advances (S_CH->S_FH sets hisNum=1; S_FH->S_DONE).
//  - S_DONE: wrEn ignored, outputs frozen except acq_count_finish=0.
//  - Counter overflow of a bin: see CONFIGURATION.
//  - Width rule: all arithmetic on bins is PEAK_MAX bits unsigned.
// CONFIGURATION
//  BIN_SATURATE_EN defined: a bin at 2**PEAK_MAX-1 stays at max; binCounts reports max.
//  Not defined: a bin wraps modulo 2**PEAK_MAX (max+1 -> 0).
// STRUCTURE
//  - Shared package/header parametersSiFH.vh: NP, NB, PEAK_MAX, ACQ_PER_HIS,
//    and the state encodings S_CH=2'd0, S_FH=2'd1, S_DONE=2'd2.
//  - One sub-module, his_bin_array: 2**NB x PEAK_MAX register file.
//    - Synchronous clear.
//    - Single increment port returning the new value (saturate/wrap logic inside).
//  - The FSM and event counter stay in the top module.
// TESTING
//  1. Hold res=0 one cycle with wrEn=1 -> binCounts=0, hisNum=0, acq_count_finish=0,
//     no bin changed.
//  2. CH: wrEn=1 with addr 1,1,2,2 on consecutive cycles -> binCounts 1,2,1,2.
//     - acq_count_finish pulses on the 4th result cycle.
//     - hisNum=1 thereafter.
//  3. FH: addr 4,7,64,42 -> binCounts 1,1,1(held: 64 rejected),1.
//     - acq_count_finish pulses.
//     - State is S_DONE; bins from CH were cleared (addr 2 in FH gives 1).
//  4. S_DONE: addr 2,4,4,3,0 with wrEn=1 -> binCounts unchanged, no pulse, hisNum=1.
//  5. res=0 mid-FH after 2 events -> hisNum=0, counter=0; CH restarts, needing 4 new events.
//  6. PEAK_MAX=2, 5 hits on bin 3:
//     - with BIN_SATURATE_EN -> binCounts 1,2,3,3,3;
//     - without -> 1,2,3,0,1.

Source files
------------

// File: rtl/his_builder_fsm_pkg.sv
// -----------------------------------------------------------------------------
// his_builder_fsm_pkg
// Shared definitions for the SiFH histogram builder:
//   - default geometry (address width, bin-address width, counter width,
//     events per histogram phase)
//   - acquisition phase state encoding
// Optional feature macro used by this code slice: BIN_SATURATE_EN
// -----------------------------------------------------------------------------
package his_builder_fsm_pkg;

  localparam int DEF_NP          = 8;  // width of the incoming bin address
  localparam int DEF_NB          = 6;  // bin-address width (2**NB bins, bin 0 unused)
  localparam int DEF_PEAK_MAX    = 8;  // width of one bin counter
  localparam int DEF_ACQ_PER_HIS = 4;  // events per histogram phase

  // Acquisition phases: coarse histogram, fine histogram, finished.
  typedef enum logic [1:0] {
    S_CH   = 2'd0,
    S_FH   = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/his_builder_fsm_bin_array.sv
// -----------------------------------------------------------------------------
// his_bin_array
// 2**NB x PEAK_MAX register-file histogram with a single increment port.
// The increment port reads the addressed bin combinationally and returns the
// new value in the same cycle, so back-to-back hits on one bin always build on
// the freshly written count (no read-modify-write hazard).
//
// Macro BIN_SATURATE_EN: defined -> a full bin stays at its maximum;
//                        undefined -> a bin wraps modulo 2**PEAK_MAX.
//
// Ports
//   clk       in   clock (rising edge)
//   res       in   synchronous active-low reset, clears every bin
//   clr       in   synchronous clear of every bin (wins over inc_en)
//   inc_en    in   increment the bin selected by inc_addr
//   inc_addr  in   [NB-1:0] bin index
//   inc_val   out  [PEAK_MAX-1:0] value the addressed bin takes when incremented
// -----------------------------------------------------------------------------
module his_bin_array #(
  parameter int NB       = 6,
  parameter int PEAK_MAX = 8
) (
  input  logic                clk,
  input  logic                res,
  input  logic                clr,
  input  logic                inc_en,
  input  logic [NB-1:0]       inc_addr,
  output logic [PEAK_MAX-1:0] inc_val
);

  localparam int NBINS = 2 ** NB;

  logic [PEAK_MAX-1:0] bin_rd [NBINS];
  logic [PEAK_MAX-1:0] cur_val;

  genvar gi;
  generate
    for (gi = 0; gi < NBINS; gi++) begin : g_bin
      logic [PEAK_MAX-1:0] bin_q;
      logic [PEAK_MAX-1:0] bin_d;

      always_comb begin
        bin_d = bin_q;
        if (clr) begin
          bin_d = '0;
        end else if (inc_en && (inc_addr == NB'(gi))) begin
          bin_d = inc_val;
        end
      end

      always_ff @(posedge clk) begin
        if (!res) begin
          bin_q <= '0;
        end else begin
          bin_q <= bin_d;
        end
      end

      assign bin_rd[gi] = bin_q;
    end
  endgenerate

  assign cur_val = bin_rd[inc_addr];

  always_comb begin
`ifdef BIN_SATURATE_EN
    inc_val = (cur_val == {PEAK_MAX{1'b1}}) ? cur_val : cur_val + PEAK_MAX'(1);
`else
    inc_val = cur_val + PEAK_MAX'(1);
`endif
  end

endmodule

// File: rtl/his_builder_fsm.sv
// -----------------------------------------------------------------------------
// his_builder_fsm
// Two-phase histogram builder for the SiFH dTOF chain. Each acquisition event
// (wrEn) in the coarse (CH) or fine (FH) phase bumps the phase event counter;
// events whose address falls inside the histogram (addr != 0 and no bits above
// NB) also increment their bin, and the bin's new count is streamed out on
// binCounts one cycle later. After ACQ_PER_HIS events the phase ends: a
// one-cycle acq_count_finish pulse, the histogram is cleared and the FSM moves
// CH -> FH -> DONE. DONE ignores wrEn until reset.
//
// Macro BIN_SATURATE_EN: bins saturate instead of wrapping (see his_bin_array).
//
// Ports
//   clk               in   clock (rising edge)
//   res               in   synchronous active-low reset
//   wrEn              in   one acquisition event this cycle
//   addr              in   [NP:1] bin address of the event
//   binCounts         out  [PEAK_MAX-1:0] updated count of last written bin
//   acq_count_finish  out  one-cycle pulse when the current phase completes
//   hisNum            out  0 = CH phase, 1 = FH phase / done
// -----------------------------------------------------------------------------
module his_builder_fsm
  import his_builder_fsm_pkg::*;
#(
  parameter int NP          = DEF_NP,
  parameter int NB          = DEF_NB,
  parameter int PEAK_MAX    = DEF_PEAK_MAX,
  parameter int ACQ_PER_HIS = DEF_ACQ_PER_HIS
) (
  input  logic                clk,
  input  logic                res,
  input  logic                wrEn,
  input  logic [NP:1]         addr,
  output logic [PEAK_MAX-1:0] binCounts,
  output logic                acq_count_finish,
  output logic                hisNum
);

  localparam int CW = $clog2(ACQ_PER_HIS + 1);

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [PEAK_MAX-1:0] bin_counts_q, bin_counts_d;
  logic                finish_q, finish_d;

  logic                evt;
  logic                accepted;
  logic                last_evt;
  logic [CW-1:0]       cnt_inc;
  logic [PEAK_MAX-1:0] inc_val;
  logic [NB-1:0]       bin_idx;

  assign bin_idx = addr[NB:1];

  his_bin_array #(
    .NB       (NB),
    .PEAK_MAX (PEAK_MAX)
  ) u_bins (
    .clk      (clk),
    .res      (res),
    .clr      (last_evt),
    .inc_en   (accepted),
    .inc_addr (bin_idx),
    .inc_val  (inc_val)
  );

  always_comb begin
    evt = wrEn && (state_q != S_DONE);
    // Addresses beyond the histogram (upper bits set) or bin 0 count as
    // events but never touch a bin.
    accepted = evt && (addr != '0) && (addr[NP:NB+1] == '0);
    cnt_inc  = cnt_q + CW'(1);
    last_evt = evt && (cnt_inc == CW'(ACQ_PER_HIS));
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bin_counts_d = bin_counts_q;
    finish_d     = 1'b0;

    if (evt) begin
      cnt_d = cnt_inc;
    end

    if (accepted) begin
      bin_counts_d = inc_val;
    end

    // The closing event still reports its bin update; the clear of the
    // histogram happens in the array on the same edge.
    if (last_evt) begin
      finish_d = 1'b1;
      cnt_d    = '0;
      state_d  = (state_q == S_CH) ? S_FH : S_DONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!res) begin
      state_q      <= S_CH;
      cnt_q        <= '0;
      bin_counts_q <= '0;
      finish_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bin_counts_q <= bin_counts_d;
      finish_q     <= finish_d;
    end
  end

  assign binCounts        = bin_counts_q;
  assign acq_count_finish = finish_q;
  assign hisNum           = (state_q != S_CH);

endmodule

// File: tb/tb_his_builder_fsm.sv
// -----------------------------------------------------------------------------
// tb_his_builder_fsm
// Two instances: the default geometry, and a narrow-counter instance
// (PEAK_MAX=2, ACQ_PER_HIS=8) that reaches bin overflow. Both are compared
// every cycle against a phase/bin-array model of the acquisition rules.
// -----------------------------------------------------------------------------
module tb_his_builder_fsm;

  logic       clk = 1'b0;
  logic       res;
  logic       wr_a, wr_b;
  logic [8:1] addr_a, addr_b;
  logic [7:0] bc_a;
  logic [1:0] bc_b;
  logic       fin_a, fin_b, his_a, his_b;

  int n_checks = 0;
  int n_errors = 0;

  // Model state: index 0 = default instance, 1 = narrow instance.
  int m_phase [2];
  int m_cnt   [2];
  int m_bc    [2];
  int m_fin   [2];
  int m_bins  [2][64];
  int m_max   [2] = '{255, 3};
  int m_acq   [2] = '{4, 8};

  always #5 clk = ~clk;

  his_builder_fsm u_dut (
    .clk              (clk),
    .res              (res),
    .wrEn             (wr_a),
    .addr             (addr_a),
    .binCounts        (bc_a),
    .acq_count_finish (fin_a),
    .hisNum           (his_a)
  );

  his_builder_fsm #(
    .NP          (8),
    .NB          (6),
    .PEAK_MAX    (2),
    .ACQ_PER_HIS (8)
  ) u_small (
    .clk              (clk),
    .res              (res),
    .wrEn             (wr_b),
    .addr             (addr_b),
    .binCounts        (bc_b),
    .acq_count_finish (fin_b),
    .hisNum           (his_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_step(input int m, input bit r, input bit we, input int a);
    if (!r) begin
      m_phase[m] = 0;
      m_cnt[m]   = 0;
      m_bc[m]    = 0;
      m_fin[m]   = 0;
      for (int i = 0; i < 64; i++) m_bins[m][i] = 0;
    end else begin
      m_fin[m] = 0;
      if (m_phase[m] < 2 && we) begin
        m_cnt[m]++;
        if (a >= 1 && a <= 63) begin
          if (m_bins[m][a] == m_max[m]) begin
`ifdef BIN_SATURATE_EN
            m_bins[m][a] = m_max[m];
`else
            m_bins[m][a] = 0;
`endif
          end else begin
            m_bins[m][a] = m_bins[m][a] + 1;
          end
          m_bc[m] = m_bins[m][a];
        end
        if (m_cnt[m] == m_acq[m]) begin
          m_fin[m] = 1;
          m_cnt[m] = 0;
          m_phase[m]++;
          for (int i = 0; i < 64; i++) m_bins[m][i] = 0;
        end
      end
    end
  endtask

  // One clock: drive inputs, advance the model at the edge, check #1 later.
  task automatic cycle(input bit r, input bit we0, input int a0, input bit we1, input int a1);
    logic [31:0] av0, av1;
    av0    = a0;
    av1    = a1;
    res    = r;
    wr_a   = we0;
    addr_a = av0[7:0];
    wr_b   = we1;
    addr_b = av1[7:0];
    @(posedge clk);
    model_step(0, r, we0, a0);
    model_step(1, r, we1, a1);
    #1;
    $display("t=%0t res=%0d A:wr=%0d addr=%0d bc=%0d fin=%0d his=%0d B:wr=%0d addr=%0d bc=%0d fin=%0d his=%0d",
             $time, r, we0, a0, bc_a, fin_a, his_a, we1, a1, bc_b, fin_b, his_b);
    chk("binCounts_a", 32'(bc_a), m_bc[0]);
    chk("finish_a",    32'(fin_a), m_fin[0]);
    chk("hisNum_a",    32'(his_a), (m_phase[0] != 0) ? 1 : 0);
    chk("binCounts_b", 32'(bc_b), m_bc[1]);
    chk("finish_b",    32'(fin_b), m_fin[1]);
    chk("hisNum_b",    32'(his_b), (m_phase[1] != 0) ? 1 : 0);
  endtask

  initial begin
    int ch_a[4] = '{1, 1, 2, 2};
    int fh_a[4] = '{4, 7, 64, 42};
    int dn_a[5] = '{2, 4, 4, 3, 0};
    int r5_a[4] = '{2, 3, 2, 9};
    int ra, rb;
    bit rr, rwa, rwb;

    res = 1'b0; wr_a = 1'b0; wr_b = 1'b0; addr_a = '0; addr_b = '0;

    // Reset held with an event present: reset wins.
    cycle(0, 1, 5, 1, 5);
    cycle(0, 1, 1, 0, 0);

    // Coarse phase: same-bin hits back to back, then phase end.
    foreach (ch_a[i]) cycle(1, 1, ch_a[i], 0, 0);
    // Fine phase including one out-of-range address.
    foreach (fh_a[i]) cycle(1, 1, fh_a[i], 0, 0);
    // Done: everything ignored.
    foreach (dn_a[i]) cycle(1, 1, dn_a[i], 0, 0);

    // Reset mid-FH after 2 events, then a fresh CH needing 4 events.
    cycle(0, 0, 0, 0, 0);
    foreach (r5_a[i]) cycle(1, 1, r5_a[i], 0, 0);
    cycle(1, 1, 2, 0, 0);   // bins cleared after CH: bin 2 restarts at 1
    cycle(1, 1, 2, 0, 0);
    cycle(0, 0, 0, 0, 0);
    cycle(1, 1, 5, 0, 0);
    cycle(1, 0, 0, 0, 0);   // idle cycle does not count
    cycle(1, 1, 5, 0, 0);
    cycle(1, 1, 0, 0, 0);   // rejected, still counts
    cycle(1, 1, 6, 0, 0);   // 4th event -> pulse

    // Narrow counters: 5 hits on bin 3 (wrap or saturate).
    cycle(0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) cycle(1, 0, 0, 1, 3);
    for (int i = 0; i < 3; i++) cycle(1, 0, 0, 1, 3);  // completes narrow CH

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      rr  = ($urandom_range(0, 39) != 0);
      rwa = ($urandom_range(0, 3) != 0);
      rwb = ($urandom_range(0, 3) != 0);
      ra  = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 6);
      rb  = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 3);
      cycle(rr, rwa, ra, rwb, rb);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
